// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between the multicycle controller and the unified memory.
// The controller drives the request side; the memory returns mem_ack.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel_instr;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_sel_instr, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_sel_instr, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-lite datapath.
// Define PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
//
//  state  | meaning
//  FETCH  | instruction read on the shared memory port, IR loads on ack
//  DECODE | classify IR; j/jr/jal retire here, illegal encodings halt
//  EXEC   | ALU operation; beq retires here
//  MEM    | data read (lw) or write (sw) on the shared memory port
//  WB     | register file write and PC advance
//  HALT   | illegal instruction or memory timeout; left only via reset
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master mem,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              zero,
  output logic              ir_we,
  output logic              pc_we,
  output logic [2:0]        npc_sel,
  output logic              grf_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wb_sel,
  output logic [1:0]        alu_op,
  output logic [1:0]        ext_op,
  output logic              alu_src,
  output logic              halt,
  output logic [2:0]        state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_tcnt;

  logic w_rtype, w_add, w_sub, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
  logic w_legal, w_tc, w_ack;

  assign w_rtype = (op == 6'h00);
  assign w_add   = w_rtype && (func == 6'h20);
  assign w_sub   = w_rtype && (func == 6'h22);
  assign w_jr    = w_rtype && (func == 6'h08);
  assign w_ori   = (op == 6'h0D);
  assign w_lw    = (op == 6'h23);
  assign w_sw    = (op == 6'h2B);
  assign w_beq   = (op == 6'h04);
  assign w_lui   = (op == 6'h0F);
  assign w_j     = (op == 6'h02);
  assign w_jal   = (op == 6'h03);
  assign w_legal = w_add | w_sub | w_jr | w_ori | w_lw | w_sw | w_beq | w_lui | w_j | w_jal;
  assign w_ack   = mem.mem_ack;

  // A same-cycle ack takes priority over the timeout terminal count.
  assign w_tc = (MEM_TIMEOUT != 0) && (r_tcnt == TC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_tcnt  <= '0;
    end else begin
      r_tcnt <= '0;
      case (r_state)
        S_FETCH: begin
          if (w_ack)     r_state <= S_DECODE;
          else if (w_tc) r_state <= S_HALT;
          else           r_tcnt  <= r_tcnt + 1'b1;
        end
        S_DECODE: begin
          if (!w_legal)                r_state <= S_HALT;
          else if (w_j | w_jr | w_jal) r_state <= S_FETCH;
          else                         r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_beq)            r_state <= S_FETCH;
          else if (w_lw | w_sw) r_state <= S_MEM;
          else                  r_state <= S_WB;
        end
        S_MEM: begin
          if (w_ack)     r_state <= w_lw ? S_WB : S_FETCH;
          else if (w_tc) r_state <= S_HALT;
          else           r_tcnt  <= r_tcnt + 1'b1;
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Strobes are decoded from the state register rather than registered so that
  // ack-qualified pulses land in the ack cycle and reset can kill them at once.
  always_comb begin
    mem.mem_req       = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_sel_instr = 1'b0;
    ir_we             = 1'b0;
    pc_we             = 1'b0;
    npc_sel           = 3'd0;
    grf_we            = 1'b0;
    reg_dst           = 2'd0;
    wb_sel            = 2'd0;
    alu_op            = 2'b00;
    ext_op            = 2'b00;
    alu_src           = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem.mem_req       = 1'b1;
        mem.mem_sel_instr = 1'b1;
        ir_we             = w_ack;
      end
      S_DECODE: begin
        if (w_j) begin
          pc_we   = 1'b1;
          npc_sel = 3'd2;
        end else if (w_jr) begin
          pc_we   = 1'b1;
          npc_sel = 3'd4;
        end else if (w_jal) begin
          pc_we   = 1'b1;
          npc_sel = 3'd3;
          grf_we  = 1'b1;
          reg_dst = 2'd2;
          wb_sel  = 2'd3;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          pc_we   = 1'b1;
          npc_sel = zero ? 3'd1 : 3'd0;
        end
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = w_sw;
        pc_we       = w_ack && w_sw;
      end
      S_WB: begin
        grf_we  = 1'b1;
        pc_we   = 1'b1;
        reg_dst = (w_add | w_sub) ? 2'd1 : 2'd0;
        wb_sel  = w_lw ? 2'd1 : (w_lui ? 2'd2 : 2'd0);
      end
      default: ;
    endcase

    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      if (w_add | w_lw | w_sw)  alu_op = 2'b01;
      else if (w_sub | w_beq)   alu_op = 2'b10;
      else if (w_ori)           alu_op = 2'b11;
      if (w_ori)                ext_op = 2'b01;
      else if (w_lw | w_sw)     ext_op = 2'b10;
      else if (w_lui)           ext_op = 2'b11;
      alu_src = w_ori | w_lw | w_sw | w_lui;
    end

    if (!reset_n) begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      grf_we      = 1'b0;
    end
  end

  assign halt  = (r_state == S_HALT);
  assign state = r_state;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (pc_we)             ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model (step lists
// per instruction class) is compared with the DUT every cycle, plus literal pins.
module tb_multicycle_ctrl;
  localparam int T = 4;
  localparam int I_ADD = 0, I_SUB = 1, I_ORI = 2, I_LW = 3, I_SW = 4, I_BEQ = 5,
                 I_LUI = 6, I_J = 7, I_JAL = 8, I_JR = 9, I_ILL = 10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_instr;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] npc_sel;
    logic       grf_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       alu_src;
    logic       halt;
    logic [2:0] state;
  } out_t;

  logic clk = 1'b0, reset_n;
  logic [5:0] op, func;
  logic zero;
  logic ir_we, pc_we, grf_we, alu_src, halt;
  logic [2:0] npc_sel, st;
  logic [1:0] reg_dst, wb_sel, alu_op, ext_op;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .mem(mif), .op(op), .func(func), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .grf_we(grf_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_op(alu_op), .ext_op(ext_op),
    .alu_src(alu_src), .halt(halt), .state(st)
`ifdef PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int m_step, m_wait, m_ins;
  bit m_halt, load_ir;
  int pend_k, force_k, ack_mode, zero_mode;
  logic [5:0] pend_op, pend_func, ill_op, ill_func;
  out_t trace[$];

  function automatic logic [11:0] enc(int k);
    case (k)
      I_ADD: return {6'h00, 6'h20};
      I_SUB: return {6'h00, 6'h22};
      I_ORI: return {6'h0D, 6'h11};
      I_LW:  return {6'h23, 6'h05};
      I_SW:  return {6'h2B, 6'h3F};
      I_BEQ: return {6'h04, 6'h00};
      I_LUI: return {6'h0F, 6'h2A};
      I_J:   return {6'h02, 6'h13};
      I_JAL: return {6'h03, 6'h08};
      default: return {6'h00, 6'h08};
    endcase
  endfunction

  // Steps: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback.
  function automatic int nsteps(int k);
    case (k)
      I_J, I_JAL, I_JR: return 2;
      I_BEQ:            return 3;
      I_LW:             return 5;
      default:          return 4;
    endcase
  endfunction

  function automatic int kind(int k, int s);
    if (s <= 2) return s;
    if (k == I_SW || (k == I_LW && s == 3)) return 3;
    return 4;
  endfunction

  function automatic int cur_kind();
    return (m_step == 0) ? 0 : kind(m_ins, m_step);
  endfunction

  function automatic bit cur_last();
    return (m_step != 0) && (m_ins != I_ILL) && (m_step == nsteps(m_ins) - 1);
  endfunction

  function automatic out_t model_out(logic a, logic z);
    out_t e;
    int kd;
    bit mem_ph, last;
    e = '0;
    if (m_halt) begin
      e.halt  = 1'b1;
      e.state = 3'd7;
      return e;
    end
    kd     = cur_kind();
    last   = cur_last();
    mem_ph = (kd == 0) || (kd == 3);
    e.state         = 3'(kd);
    e.mem_req       = mem_ph;
    e.mem_sel_instr = (kd == 0);
    e.mem_we        = (kd == 3) && (m_ins == I_SW);
    e.ir_we         = (kd == 0) && a;
    e.pc_we         = last && (!mem_ph || a);
    if (last) begin
      case (m_ins)
        I_J:   e.npc_sel = 3'd2;
        I_JAL: e.npc_sel = 3'd3;
        I_JR:  e.npc_sel = 3'd4;
        I_BEQ: e.npc_sel = z ? 3'd1 : 3'd0;
        default: e.npc_sel = 3'd0;
      endcase
      if (m_ins inside {I_ADD, I_SUB, I_ORI, I_LUI, I_LW, I_JAL}) begin
        e.grf_we  = 1'b1;
        e.reg_dst = (m_ins == I_JAL) ? 2'd2 : ((m_ins == I_ADD || m_ins == I_SUB) ? 2'd1 : 2'd0);
        e.wb_sel  = (m_ins == I_JAL) ? 2'd3 : (m_ins == I_LW) ? 2'd1 : (m_ins == I_LUI) ? 2'd2 : 2'd0;
      end
    end
    if (kd >= 2) begin
      case (m_ins)
        I_ADD:       {e.alu_op, e.ext_op, e.alu_src} = 5'b01_00_0;
        I_SUB, I_BEQ:{e.alu_op, e.ext_op, e.alu_src} = 5'b10_00_0;
        I_ORI:       {e.alu_op, e.ext_op, e.alu_src} = 5'b11_01_1;
        I_LW, I_SW:  {e.alu_op, e.ext_op, e.alu_src} = 5'b01_10_1;
        I_LUI:       {e.alu_op, e.ext_op, e.alu_src} = 5'b00_11_1;
        default:     {e.alu_op, e.ext_op, e.alu_src} = 5'b00_00_0;
      endcase
    end
    return e;
  endfunction

  task automatic model_step(logic a);
    int kd;
    if (m_halt) return;
    kd = cur_kind();
    if ((kd == 0 || kd == 3) && !a) begin
      m_wait++;
      if (m_wait == T) m_halt = 1'b1;
      return;
    end
    m_wait = 0;
    if (m_step == 0) begin
      m_ins   = pend_k;
      m_step  = 1;
      load_ir = 1'b1;
    end else if (m_ins == I_ILL) m_halt = 1'b1;
    else if (cur_last()) m_step = 0;
    else m_step++;
  endtask

  function automatic out_t sample();
    out_t s;
    s.mem_req = mif.mem_req;   s.mem_we = mif.mem_we;   s.mem_sel_instr = mif.mem_sel_instr;
    s.ir_we = ir_we;           s.pc_we = pc_we;         s.npc_sel = npc_sel;
    s.grf_we = grf_we;         s.reg_dst = reg_dst;     s.wb_sel = wb_sel;
    s.alu_op = alu_op;         s.ext_op = ext_op;       s.alu_src = alu_src;
    s.halt = halt;             s.state = st;
    return s;
  endfunction

  task automatic pick_next();
    int r;
    logic [11:0] e;
    if (force_k == -2) begin
      r = $urandom_range(0, 39);
      if (r < 2) begin
        pend_k = I_ILL;
        case ($urandom_range(0, 3))
          0: e = {6'h3F, 6'h00};
          1: e = {6'h00, 6'h21};
          2: e = {6'h08, 6'h00};
          default: e = {6'h00, 6'h3F};
        endcase
      end else begin
        pend_k = r % 10;
        e = enc(pend_k);
      end
    end else begin
      pend_k = force_k;
      e = (force_k == I_ILL) ? {ill_op, ill_func} : enc(force_k);
    end
    pend_op   = e[11:6];
    pend_func = e[5:0];
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, then compare at the falling edge.
  task automatic body();
    logic a;
    int kd;
    bit mem_ph;
    out_t got, exp;
    if (load_ir) begin
      op = pend_op;
      func = pend_func;
      load_ir = 1'b0;
      pick_next();
    end
    zero = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
    kd = cur_kind();
    mem_ph = !m_halt && (kd == 0 || kd == 3);
    case (ack_mode)
      0: a = (mem_ph && m_wait >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      1: a = 1'b0;
      2: a = mem_ph ? (m_wait == 3) : 1'($urandom_range(0, 1));
      3: a = mem_ph ? 1'b1 : 1'($urandom_range(0, 1));
      default: a = mem_ph ? (kd == 0) : 1'($urandom_range(0, 1));
    endcase
    mif.mem_ack = a;
    @(negedge clk);
    cyc++;
    got = sample();
    exp = model_out(a, zero);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle %0d outputs got %h exp %h", cyc, got, exp);
    end
    trace.push_back(got);
    model_step(a);
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      body();
    end
  endtask

  task automatic do_reset();
    out_t s;
    reset_n = 1'b0;
    mif.mem_ack = 1'b0;
    load_ir = 1'b0;
    repeat (2) @(negedge clk);
    s = sample();
    chk("reset_strobes", {s.mem_req, s.mem_we, s.ir_we, s.pc_we, s.grf_we, s.halt, s.state}, 0);
    m_step = 0;
    m_wait = 0;
    m_halt = 1'b0;
    m_ins  = I_ADD;
    pick_next();
    trace.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    body();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] s5;
    int n;
    reset_n = 1'b0; op = 6'h00; func = 6'h00; zero = 1'b0; mif.mem_ack = 1'b0;
    force_k = I_ADD; ack_mode = 3; zero_mode = -1; ill_op = 6'h3F; ill_func = 6'h00;

    // add with immediate ack: 0,1,2,4,0 and one retire
    do_reset();
    run(4);
    chk("first_fetch_req", trace[0].mem_req, 1);
    s5 = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      s5 = {s5[11:0], trace[i].state};
      n += int'(trace[i].pc_we);
    end
    chk("add_states", s5, 15'o01240);
    chk("add_pc_we_count", n, 1);
    chk("add_wb", {trace[3].grf_we, trace[3].reg_dst, trace[3].wb_sel}, {1'b1, 2'd1, 2'd0});

    // jal retires in DECODE
    force_k = I_JAL;
    do_reset();
    run(2);
    chk("jal_decode", {trace[1].pc_we, trace[1].npc_sel, trace[1].grf_we, trace[1].reg_dst, trace[1].wb_sel},
        {1'b1, 3'd3, 1'b1, 2'd2, 2'd3});
    chk("jal_next_fetch", {trace[2].state, trace[2].mem_req}, {3'd0, 1'b1});

    // lw with ack on the 4th request cycle (timeout boundary: ack wins)
    force_k = I_LW; ack_mode = 2;
    do_reset();
    run(11);
    n = 0;
    for (int i = 0; i < 12; i++) if (trace[i].state == 3'd3 && trace[i].mem_req) n++;
    chk("lw_mem_req_cycles", n, 4);
    n = 0;
    for (int i = 0; i < 12; i++) n += int'(trace[i].mem_we);
    chk("lw_mem_we", n, 0);
    chk("lw_wb", {trace[10].state, trace[10].grf_we, trace[10].wb_sel, trace[10].reg_dst}, {3'd4, 1'b1, 2'd1, 2'd0});

    // beq taken, then not taken
    force_k = I_BEQ; ack_mode = 3; zero_mode = 1;
    do_reset();
    run(2);
    chk("beq_taken", {trace[2].state, trace[2].pc_we, trace[2].npc_sel, trace[2].grf_we}, {3'd2, 1'b1, 3'd1, 1'b0});
    zero_mode = 0;
    run(3);
    chk("beq_not_taken", {trace[5].state, trace[5].pc_we, trace[5].npc_sel, trace[5].grf_we}, {3'd2, 1'b1, 3'd0, 1'b0});
    zero_mode = -1;

    // fetch timeout
    force_k = -2; ack_mode = 1;
    do_reset();
    run(7);
    chk("timeout_before", {trace[3].mem_req, trace[3].halt}, {1'b1, 1'b0});
    chk("timeout_halt", {trace[4].mem_req, trace[4].halt, trace[4].state}, {1'b0, 1'b1, 3'd7});
    chk("halt_sticky", {trace[7].mem_req, trace[7].halt}, {1'b0, 1'b1});
    ack_mode = 3;
    do_reset();
    chk("reset_clears_halt", {trace[0].halt, trace[0].state, trace[0].mem_req}, {1'b0, 3'd0, 1'b1});

    // illegal opcode and illegal R-type func
    force_k = I_ILL;
    do_reset();
    run(3);
    chk("ill_op_halt", {trace[1].state, trace[2].state, trace[2].halt}, {3'd1, 3'd7, 1'b1});
    ill_op = 6'h00; ill_func = 6'h3F;
    do_reset();
    run(2);
    chk("ill_func_halt", {trace[2].state, trace[2].halt}, {3'd7, 1'b1});

    // reset asserted while sw waits in MEM
    force_k = I_SW; ack_mode = 4;
    do_reset();
    run(4);
    chk("sw_in_mem", {trace[4].state, trace[4].mem_req, trace[4].mem_we}, {3'd3, 1'b1, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    chk("sw_async_reset", {mif.mem_req, mif.mem_we, st}, 0);

    // randomized instruction streams with random memory latency
    force_k = -2; ack_mode = 0;
    for (int seg = 0; seg < 10; seg++) begin
      do_reset();
      run(200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
